// File: rtl/systolic_pkg.sv
// Shared constants, result type and bus helpers for the systolic array slice.
package systolic_pkg;

    localparam int unsigned COLS  = 8;
    localparam int unsigned MAC_W = 19;
    localparam int unsigned X_W   = 8;
    localparam int unsigned W_W   = 8;

    typedef logic signed [MAC_W-1:0] mac_t;

    // Extract column c from a packed COLS*MAC_W bus.
    function automatic mac_t col_slice(input logic [COLS*MAC_W-1:0] bus,
                                       input int unsigned           c);
        return mac_t'(bus[c*MAC_W +: MAC_W]);
    endfunction

endpackage

// File: rtl/drain_col_fifo.sv
// Single-column result FIFO for the drain collector; reports refused pushes.
module drain_col_fifo
    import systolic_pkg::*;
#(
    parameter int unsigned W     = MAC_W,
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the head slot, so a full FIFO may still accept.
    assign do_pop  = pop_i && !empty_o && !clr_i;
    assign do_push = push_i && (!full_o || do_pop) && !clr_i;
    assign drop_o  = push_i && !clr_i && full_o && !do_pop;

    assign head_o  = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear empties the FIFO and overrides push/pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; zeroed on reset so the idle head reads as 0.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Bottom-edge collector: deskews column results into aligned rows with ready/valid.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int unsigned COLS  = systolic_pkg::COLS,
    parameter int unsigned MAC_W = systolic_pkg::MAC_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ROWS  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [COLS*MAC_W-1:0]    mac_i,
    input  logic [COLS-1:0]          mac_v_i,
    input  logic                     clr_i,
    output logic [COLS*MAC_W-1:0]    out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [$clog2(ROWS)-1:0]  out_idx_o,
    output logic                     out_last_o,
    output logic                     ovf_o
);

    localparam int unsigned IW = $clog2(ROWS);
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

    logic [COLS-1:0] col_empty;
    logic [COLS-1:0] col_full_unused;
    logic [COLS-1:0] col_drop;
    logic            pop;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        drain_col_fifo #(
            .W     (MAC_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (clr_i),
            .push_i  (mac_v_i[c]),
            .data_i  (mac_i[c*MAC_W +: MAC_W]),
            .pop_i   (pop),
            .head_o  (out_data_o[c*MAC_W +: MAC_W]),
            .empty_o (col_empty[c]),
            .full_o  (col_full_unused[c]),
            .drop_o  (col_drop[c])
        );
    end

    // A row exists only once every column holds at least one entry.
    assign out_valid_o = &(~col_empty);
    assign pop         = out_valid_o && out_ready_i;
    assign out_last_o  = out_valid_o && (out_idx_o == LAST_IDX);

    // Row index within the tile, advancing on each accepted row.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_idx_o <= '0;
        end else if (clr_i) begin
            out_idx_o <= '0;
        end else if (pop) begin
            out_idx_o <= (out_idx_o == LAST_IDX) ? '0 : out_idx_o + IW'(1);
        end
    end

    // Sticky loss flag; clear wins over a same-cycle drop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_o <= 1'b0;
        end else if (clr_i) begin
            ovf_o <= 1'b0;
        end else if (|col_drop) begin
            ovf_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: alignment, skew, full/overflow, clear, reset.
module tb_systolic_drain;
    import systolic_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic [COLS*MAC_W-1:0]  mac;
    logic [COLS-1:0]        mac_v;
    logic                   clr;
    logic [COLS*MAC_W-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [2:0]             out_idx;
    logic                   out_last;
    logic                   ovf;

    int total = 0;
    int bad   = 0;

    systolic_drain #(
        .COLS  (COLS),
        .MAC_W (MAC_W),
        .DEPTH (16),
        .ROWS  (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mac_i       (mac),
        .mac_v_i     (mac_v),
        .clr_i       (clr),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put(input int unsigned c, input int v);
        mac[c*MAC_W +: MAC_W] = mac_t'(v);
    endtask

    task automatic test_reset();
        rst_i = 1'b0; mac = '0; mac_v = '0; clr = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got %0h want 0", out_data); end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got %0d want 0", out_idx); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got %0b want 0", out_last); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_aligned();
        for (int unsigned c = 0; c < COLS; c++) put(c, int'(c) * 10 - 40);
        mac_v = '1; out_ready = 1'b1;
        step();
        mac_v = '0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL aligned_valid got %0b want 1", out_valid); end
        for (int unsigned c = 0; c < COLS; c++) begin
            total++;
            if (col_slice(out_data, c) !== mac_t'(int'(c) * 10 - 40)) begin
                bad++; $display("FAIL aligned_col%0d got %0d want %0d", c, col_slice(out_data, c), int'(c) * 10 - 40);
            end
        end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL aligned_idx got %0d want 0", out_idx); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL aligned_last got %0b want 0", out_last); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL aligned_after_valid got %0b want 0", out_valid); end
        total++; if (out_idx !== 3'd1) begin bad++; $display("FAIL aligned_after_idx got %0d want 1", out_idx); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL aligned_clr_idx got %0d want 0", out_idx); end
    endtask

    task automatic test_skewed();
        logic [MAC_W-1:0] all_ones;
        logic [2:0]       exp_idx;
        logic             exp_valid;
        logic             exp_last;
        int               r;
        all_ones = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            mac_v = '0;
            for (int c = 0; c < int'(COLS); c++) begin
                if (k >= c && k <= c + 7) begin
                    r = k - c;
                    put(c, (r == 0 && c == 0) ? -1 : r * 8 + c);
                    mac_v[c] = 1'b1;
                end
            end
            step();
            exp_valid = (k >= 7 && k <= 14);
            r = k - 7;
            exp_last = exp_valid && (r == 7);
            total++; if (out_valid !== exp_valid) begin bad++; $display("FAIL skew_valid k=%0d got %0b want %0b", k, out_valid, exp_valid); end
            total++; if (out_last !== exp_last) begin bad++; $display("FAIL skew_last k=%0d got %0b want %0b", k, out_last, exp_last); end
            if (exp_valid) begin
                exp_idx = 3'(r);
                total++; if (out_idx !== exp_idx) begin bad++; $display("FAIL skew_idx row=%0d got %0d want %0d", r, out_idx, exp_idx); end
                for (int c = 0; c < int'(COLS); c++) begin
                    total++;
                    if (col_slice(out_data, c) !== mac_t'((r == 0 && c == 0) ? -1 : r * 8 + c)) begin
                        bad++; $display("FAIL skew_data row=%0d col=%0d got %0d want %0d", r, c, col_slice(out_data, c), (r == 0 && c == 0) ? -1 : r * 8 + c);
                    end
                end
                if (r == 0) begin
                    total++;
                    if (out_data[MAC_W-1:0] !== all_ones) begin bad++; $display("FAIL skew_neg_bits got %0h want %0h", out_data[MAC_W-1:0], all_ones); end
                end
            end
        end
        mac_v = '0;
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL skew_wrap_idx got %0d want 0", out_idx); end
    endtask

    task automatic test_full_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            mac_v = 8'h01; put(0, 100 + i);
            step();
        end
        mac_v = '1; put(0, 115);
        for (int unsigned c = 1; c < COLS; c++) put(c, 200 + int'(c));
        step();
        mac_v = '0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got %0b want 1", out_valid); end
        total++; if (col_slice(out_data, 0) !== mac_t'(100)) begin bad++; $display("FAIL full_head got %0d want 100", col_slice(out_data, 0)); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_ovf got %0b want 0", ovf); end
        // full column: push and pop in the same cycle
        out_ready = 1'b1; mac_v = 8'h01; put(0, 116);
        step();
        out_ready = 1'b0; mac_v = '0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got %0b want 0", ovf); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_valid got %0b want 0", out_valid); end
        mac_v = 8'hFE;
        for (int unsigned c = 1; c < COLS; c++) put(c, 300 + int'(c));
        step();
        mac_v = '0;
        total++; if (col_slice(out_data, 0) !== mac_t'(101)) begin bad++; $display("FAIL pushpop_head got %0d want 101", col_slice(out_data, 0)); end
        // overflow: full, no pop
        mac_v = 8'h01; put(0, 'h12345);
        step();
        mac_v = '0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got %0b want 1", ovf); end
        total++; if (col_slice(out_data, 0) !== mac_t'(101)) begin bad++; $display("FAIL ovf_head got %0d want 101", col_slice(out_data, 0)); end
        step();
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_held got %0b want 1", ovf); end
        // drain column 0 and confirm exactly 101..116 were kept
        out_ready = 1'b1; mac_v = 8'hFE;
        for (int i = 0; i < 16; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid i=%0d got %0b want 1", i, out_valid); end
            total++; if (col_slice(out_data, 0) !== mac_t'(101 + i)) begin bad++; $display("FAIL drain_col0 i=%0d got %0d want %0d", i, col_slice(out_data, 0), 101 + i); end
            step();
        end
        mac_v = '0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_valid got %0b want 0", out_valid); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL drain_ovf got %0b want 1", ovf); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mac_v = '1;
            for (int unsigned c = 0; c < COLS; c++) put(c, 400 + int'(c) + 8 * i);
            step();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_pre_valid got %0b want 1", out_valid); end
        clr = 1'b1; mac_v = '1;
        for (int unsigned c = 0; c < COLS; c++) put(c, 999);
        step();
        clr = 1'b0; mac_v = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got %0b want 0", out_valid); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL clr_ovf got %0b want 0", ovf); end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL clr_idx got %0d want 0", out_idx); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_push_discard got %0b want 0", out_valid); end
        // empty column blocks the row
        for (int i = 0; i < 2; i++) begin
            mac_v = 8'h7F;
            for (int unsigned c = 0; c < COLS; c++) put(c, 700 + int'(c) + 8 * i);
            step();
        end
        mac_v = '0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL partial_valid got %0b want 0", out_valid); end
        mac_v = 8'h80; put(7, -5);
        step();
        mac_v = '0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL partial_done_valid got %0b want 1", out_valid); end
        total++; if (col_slice(out_data, 0) !== mac_t'(700)) begin bad++; $display("FAIL partial_col0 got %0d want 700", col_slice(out_data, 0)); end
        total++; if (col_slice(out_data, 7) !== mac_t'(-5)) begin bad++; $display("FAIL partial_col7 got %0d want -5", col_slice(out_data, 7)); end
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mac_v = '1;
            for (int unsigned c = 0; c < COLS; c++) put(c, 500 + int'(c) + 8 * i);
            step();
        end
        mac_v = '0; out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        total++; if (out_idx !== 3'd4) begin bad++; $display("FAIL mid_idx got %0d want 4", out_idx); end
        total++; if (col_slice(out_data, 0) !== mac_t'(532)) begin bad++; $display("FAIL mid_head got %0d want 532", col_slice(out_data, 0)); end
        #2 rst_i = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got %0b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL arst_data got %0h want 0", out_data); end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL arst_idx got %0d want 0", out_idx); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL arst_last got %0b want 0", out_last); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL arst_ovf got %0b want 0", ovf); end
        step();
        rst_i = 1'b1;
        mac_v = '1; out_ready = 1'b1;
        for (int unsigned c = 0; c < COLS; c++) put(c, 600 + int'(c));
        step();
        mac_v = '0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_valid got %0b want 1", out_valid); end
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL post_idx got %0d want 0", out_idx); end
        total++; if (col_slice(out_data, 0) !== mac_t'(600)) begin bad++; $display("FAIL post_col0 got %0d want 600", col_slice(out_data, 0)); end
        total++; if (col_slice(out_data, 7) !== mac_t'(607)) begin bad++; $display("FAIL post_col7 got %0d want 607", col_slice(out_data, 7)); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_drained_valid got %0b want 0", out_valid); end
        total++; if (out_idx !== 3'd1) begin bad++; $display("FAIL post_drained_idx got %0d want 1", out_idx); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skewed();
        test_full_overflow();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
